mb_scheduler: RTL

Frame-level sequencer for the intra-prediction loop. Walks macroblocks in raster order and, for each one, drives the neighbour extractor (enable + packed mbnumber), then hands off to the predictor and the reconstruction stage through start/done handshakes. It advances to the next macroblock only after the current one is reconstructed, so the extractor always reads finished neighbours.

---
 rtl/mb_scheduler.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/mb_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : mb_scheduler
//  Purpose  : Raster-order macroblock sequencer for the intra-prediction loop;
//             extract -> predict -> reconstruct handshakes per macroblock.
//  Revision : 1.0
// ============================================================================
module mb_scheduler #(
    parameter int WIDTH       = 1280,
    parameter int LENGTH      = 720,
    parameter int MB_SIZE_L   = 16,
    parameter int MB_SIZE_W   = 16,
    parameter int EXTRACT_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    output logic        extract_enable,
    output logic [31:0] mbnumber,
    output logic        pred_start,
    input  logic        pred_done,
    output logic        recon_start,
    input  logic        recon_done,
    output logic        busy,
    output logic        frame_done,
    output logic [31:0] mb_count
);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_FETCH      = 3'd1;
    localparam logic [2:0] S_WAIT_EXT   = 3'd2;
    localparam logic [2:0] S_PRED       = 3'd3;
    localparam logic [2:0] S_WAIT_PRED  = 3'd4;
    localparam logic [2:0] S_RECON      = 3'd5;
    localparam logic [2:0] S_WAIT_RECON = 3'd6;
    localparam logic [2:0] S_ADVANCE    = 3'd7;

    localparam logic [15:0] LAST_COL = 16'(LENGTH - MB_SIZE_W);
    localparam logic [15:0] LAST_ROW = 16'(WIDTH - MB_SIZE_L);
    localparam logic [15:0] COL_STEP = 16'(MB_SIZE_W);
    localparam logic [15:0] ROW_STEP = 16'(MB_SIZE_L);
    localparam logic [3:0]  LAT_INIT = 4'(EXTRACT_LAT);

    logic [2:0]  state_q, state_d;
    logic [15:0] row_q, row_d;
    logic [15:0] col_q, col_d;
    logic [3:0]  lat_q, lat_d;
    logic [31:0] mbnumber_q, mbnumber_d;
    logic [31:0] mb_count_q, mb_count_d;
    logic        extract_enable_q, extract_enable_d;
    logic        pred_start_q, pred_start_d;
    logic        recon_start_q, recon_start_d;
    logic        busy_q, busy_d;
    logic        frame_done_q, frame_done_d;

    logic        w_last_col;
    logic        w_last_mb;

    assign w_last_col = (col_q == LAST_COL);
    assign w_last_mb  = w_last_col && (row_q == LAST_ROW);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q          <= S_IDLE;
            row_q            <= '0;
            col_q            <= '0;
            lat_q            <= '0;
            mbnumber_q       <= '0;
            mb_count_q       <= '0;
            extract_enable_q <= 1'b0;
            pred_start_q     <= 1'b0;
            recon_start_q    <= 1'b0;
            busy_q           <= 1'b0;
            frame_done_q     <= 1'b0;
        end else begin
            state_q          <= state_d;
            row_q            <= row_d;
            col_q            <= col_d;
            lat_q            <= lat_d;
            mbnumber_q       <= mbnumber_d;
            mb_count_q       <= mb_count_d;
            extract_enable_q <= extract_enable_d;
            pred_start_q     <= pred_start_d;
            recon_start_q    <= recon_start_d;
            busy_q           <= busy_d;
            frame_done_q     <= frame_done_d;
        end
    end

    // Abort wins over every done input; IDLE itself only listens to start.
    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        lat_d      = lat_q;
        mb_count_d = mb_count_q;
        if ((state_q != S_IDLE) && abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        row_d      = '0;
                        col_d      = '0;
                        mb_count_d = '0;
                        state_d    = S_FETCH;
                    end
                end
                S_FETCH: begin
                    lat_d   = LAT_INIT;
                    state_d = S_WAIT_EXT;
                end
                S_WAIT_EXT: begin
                    lat_d = lat_q - 4'd1;
                    if (lat_q <= 4'd1) begin
                        state_d = S_PRED;
                    end
                end
                S_PRED: state_d = S_WAIT_PRED;
                S_WAIT_PRED: begin
                    if (pred_done) begin
                        state_d = S_RECON;
                    end
                end
                S_RECON: state_d = S_WAIT_RECON;
                S_WAIT_RECON: begin
                    if (recon_done) begin
                        mb_count_d = mb_count_q + 32'd1;
                        state_d    = S_ADVANCE;
                    end
                end
                S_ADVANCE: begin
                    if (w_last_mb) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_FETCH;
                        if (w_last_col) begin
                            col_d = '0;
                            row_d = row_q + ROW_STEP;
                        end else begin
                            col_d = col_q + COL_STEP;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state so they are registered yet
    // line up with the state they belong to.
    always_comb begin
        extract_enable_d = (state_d == S_FETCH);
        pred_start_d     = (state_d == S_PRED);
        recon_start_d    = (state_d == S_RECON);
        busy_d           = (state_d != S_IDLE);
        frame_done_d     = (state_d == S_ADVANCE) && w_last_mb;
        mbnumber_d       = (state_d == S_FETCH) ? {row_d, col_d} : mbnumber_q;
    end

    assign extract_enable = extract_enable_q;
    assign mbnumber       = mbnumber_q;
    assign pred_start     = pred_start_q;
    assign recon_start    = recon_start_q;
    assign busy           = busy_q;
    assign frame_done     = frame_done_q;
    assign mb_count       = mb_count_q;

endmodule
`default_nettype wire
